// File: rtl/id_stage.sv
// LEGv8 instruction-decode stage: 32 x WORD register file (X31 = XZR) plus immediate extension.
// Optional build macro ID_WR_BYPASS_EN forwards w_data to a read port that matches the write register.
module id_stage #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INST_SIZE-1:0] inst,
    input  logic                 RegWrite,
    input  logic                 Reg2Loc,
    input  logic                 WRegLoc,
    input  logic [WORD-1:0]      w_data,
    output logic [WORD-1:0]      r_data1,
    output logic [WORD-1:0]      r_data2,
    output logic [WORD-1:0]      ex_data
);

    localparam logic [4:0] XZR = 5'd31;
    localparam logic [4:0] XLR = 5'd30;

    logic [WORD-1:0] regs [0:31];
    logic [4:0]      rn_sel;
    logic [4:0]      r2_sel;
    logic [4:0]      wr_sel;
    logic            wr_en;

    assign rn_sel = inst[9:5];
    assign r2_sel = Reg2Loc ? inst[4:0] : inst[20:16];
    assign wr_sel = WRegLoc ? XLR : inst[4:0];
    assign wr_en  = RegWrite && (wr_sel != XZR);

    // Entry 31 is never written, so it stays zero from reset onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_sel] <= w_data;
        end
    end

    always_comb begin
        r_data1 = (rn_sel == XZR) ? '0 : regs[rn_sel];
        r_data2 = (r2_sel == XZR) ? '0 : regs[r2_sel];
`ifdef ID_WR_BYPASS_EN
        if (rst_n && wr_en && (rn_sel == wr_sel)) begin
            r_data1 = w_data;
        end
        if (rst_n && wr_en && (r2_sel == wr_sel)) begin
            r_data2 = w_data;
        end
`endif
    end

    always_comb begin
        ex_data = {{(WORD-INST_SIZE){1'b0}}, inst};
        if (inst[31:26] inside {6'b000101, 6'b100101}) begin
            ex_data = {{(WORD-26){inst[25]}}, inst[25:0]};
        end else if (inst[31:24] inside {8'hB4, 8'hB5}) begin
            ex_data = {{(WORD-19){inst[23]}}, inst[23:5]};
        end else if (inst[31:21] inside {11'h7C2, 11'h7C0, 11'h1C2, 11'h1C0,
                                         11'h3C2, 11'h3C0, 11'h5C4, 11'h5C0}) begin
            ex_data = {{(WORD-9){inst[20]}}, inst[20:12]};
        end else if (inst[31:22] inside {10'h244, 10'h2C4, 10'h344, 10'h3C4,
                                         10'h248, 10'h3C8, 10'h2C8, 10'h348}) begin
            ex_data = {{(WORD-12){1'b0}}, inst[21:10]};
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a register-array/opcode-table model checked every negedge,
// plus literal expectations from hand-decoded LEGv8 encodings.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        RegWrite = 1'b0;
    logic        Reg2Loc = 1'b0;
    logic        WRegLoc = 1'b0;
    logic [63:0] w_data = 64'h0;
    logic [63:0] r_data1, r_data2, ex_data;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [63:0] model [32];

    id_stage #(.WORD(64), .INST_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .RegWrite(RegWrite),
        .Reg2Loc(Reg2Loc), .WRegLoc(WRegLoc), .w_data(w_data),
        .r_data1(r_data1), .r_data2(r_data2), .ex_data(ex_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
        end
    endtask

    // Sign-extend an n-bit field by subtracting 2^n when its top bit is set.
    function automatic logic [63:0] sext(input longint unsigned v, input int n);
        if (((v >> (n - 1)) & 1) != 0) return 64'(v - (64'd1 << n));
        return 64'(v);
    endfunction

    function automatic logic [63:0] model_ex(input logic [31:0] i);
        longint unsigned u = i;
        longint unsigned op6 = u >> 26, op8 = u >> 24, op11 = u >> 21, op10 = u >> 22;
        if (op6 == 'h05 || op6 == 'h25) return sext(u % (1 << 26), 26);
        if (op8 == 'hB4 || op8 == 'hB5) return sext((u >> 5) % (1 << 19), 19);
        if (op11 == 'h7C2 || op11 == 'h7C0 || op11 == 'h1C2 || op11 == 'h1C0 ||
            op11 == 'h3C2 || op11 == 'h3C0 || op11 == 'h5C4 || op11 == 'h5C0)
            return sext((u >> 12) % (1 << 9), 9);
        if (op10 == 'h244 || op10 == 'h2C4 || op10 == 'h344 || op10 == 'h3C4 ||
            op10 == 'h248 || op10 == 'h3C8 || op10 == 'h2C8 || op10 == 'h348)
            return 64'((u >> 10) % (1 << 12));
        return 64'(u);
    endfunction

    function automatic int wr_reg();
        return WRegLoc ? 30 : int'(inst[4:0]);
    endfunction

    function automatic logic [63:0] model_read(input int r);
        logic [63:0] v = (r == 31) ? 64'h0 : model[r];
`ifdef ID_WR_BYPASS_EN
        if (rst_n && RegWrite && r != 31 && r == wr_reg()) v = w_data;
`endif
        return v;
    endfunction

    initial for (int k = 0; k < 32; k++) model[k] = 64'h0;

    always @(negedge rst_n) for (int k = 0; k < 32; k++) model[k] = 64'h0;

    always @(posedge clk) begin
        if (rst_n && RegWrite && wr_reg() != 31) model[wr_reg()] = w_data;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_r_data1", r_data1, model_read(int'(inst[9:5])));
            check("cyc_r_data2", r_data2, model_read(Reg2Loc ? int'(inst[4:0]) : int'(inst[20:16])));
            check("cyc_ex_data", ex_data, model_ex(inst));
        end
    end

    task automatic step(input logic [31:0] i, input logic rw, input logic r2l,
                        input logic wrl, input logic [63:0] wd);
        @(posedge clk);
        #2;
        inst = i; RegWrite = rw; Reg2Loc = r2l; WRegLoc = wrl; w_data = wd;
        #1;
    endtask

    initial begin
        #1;
        chk_en = 1'b1;
        check("reset_r_data1", r_data1, 64'h0);
        check("reset_r_data2", r_data2, 64'h0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;

        step(32'hF84402C9, 1, 0, 0, 64'd1);
        check("ldur_ex", ex_data, 64'd64);
        check("ldur_rn_x22", r_data1, 64'h0);

        step(32'h8B09026A, 1, 0, 0, 64'd20);
        check("add_rm_x9", r_data2, 64'd1);
        check("add_ex_pass", ex_data, 64'h0000_0000_8B09_026A);

        step(32'h8B09026B, 1, 0, 0, 64'h1234);
        step(32'hF80602CB, 0, 1, 0, 64'h0);
        check("stur_rt_x11", r_data2, 64'h1234);
        check("stur_ex", ex_data, 64'd96);

        step(32'hB4FFFF6B, 0, 0, 0, 64'h0);
        check("cbz_ex_neg", ex_data, 64'hFFFF_FFFF_FFFF_FFFB);
        step(32'h14000040, 0, 0, 0, 64'h0);
        check("b_ex_pos", ex_data, 64'd64);
        step(32'h17FFFFC9, 0, 0, 0, 64'h0);
        check("b_ex_neg", ex_data, 64'hFFFF_FFFF_FFFF_FFC9);
        step(32'h913FFC00, 0, 0, 0, 64'h0);
        check("addi_ex_zext", ex_data, 64'h0000_0000_0000_0FFF);

        step(32'hAA150149, 0, 0, 0, 64'h0);
        check("orr_rn_x10", r_data1, 64'd20);

        step(32'h8B09027F, 1, 0, 0, 64'd5);
        step(32'hAA1F03E0, 0, 0, 0, 64'h0);
        check("xzr_rd1", r_data1, 64'h0);
        check("xzr_rd2", r_data2, 64'h0);

        step(32'hAA150149, 1, 0, 1, 64'd7);
        step(32'hF80603C9, 0, 1, 0, 64'h0);
        check("link_x30", r_data1, 64'd7);
        check("x9_kept", r_data2, 64'd1);

        step(32'hAA15014A, 1, 0, 0, 64'h55);
`ifdef ID_WR_BYPASS_EN
        check("bypass_rd1", r_data1, 64'h55);
`else
        check("nobypass_rd1", r_data1, 64'd20);
`endif

        step(32'hF80603C9, 0, 1, 0, 64'h0);
        check("pre_rst_x30", r_data1, 64'd7);
        rst_n = 1'b0;
        #1;
        check("rst_rd1", r_data1, 64'h0);
        check("rst_rd2", r_data2, 64'h0);
        check("rst_ex_follow", ex_data, 64'd96);
        RegWrite = 1'b1; WRegLoc = 1'b1; w_data = 64'd99;
        @(posedge clk);
        #1;
        check("rst_wins", r_data1, 64'h0);
        #2 rst_n = 1'b1;
        #1;
`ifdef ID_WR_BYPASS_EN
        check("post_rst_rd1", r_data1, 64'd99);
`else
        check("post_rst_rd1", r_data1, 64'h0);
`endif
        @(posedge clk);
        #1;
        check("first_write_after_rst", r_data1, 64'd99);
        check("x9_cleared", r_data2, 64'h0);

        step(32'hAA150149, 0, 0, 0, 64'h0);
        check("x10_cleared", r_data1, 64'h0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
